// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB/I2C register target.
package sccb_pkg;

  localparam logic [6:0]  OV7670_DEV_ADDR    = 7'h21;
  localparam int unsigned SCCB_BITS_PER_BYTE = 8;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    ACK_DEV,
    SUBADDR,
    ACK_SUB,
    WRDATA,
    ACK_WR,
    RDDATA,
    RD_ACK,
    WAIT_STOP
  } sccb_slave_state_t;

  // Majority vote of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// scl/sda synchronizers, edge registers and START/STOP/edge decode.
// Optional majority glitch filter enabled by SCCB_GLITCH_FILTER_EN.
module sccb_line_sync
  import sccb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Synchronizer chains; idle bus level is high so reset to ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
    end
  end

`ifdef SCCB_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist;
  logic [1:0] r_sda_hist;
  logic       r_scl_f;
  logic       r_sda_f;

  // Three-sample majority filter rejects single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[SYNC_STAGES-1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[SYNC_STAGES-1]};
      r_scl_f    <= maj3(r_scl_sync[SYNC_STAGES-1], r_scl_hist[0], r_scl_hist[1]);
      r_sda_f    <= maj3(r_sda_sync[SYNC_STAGES-1], r_sda_hist[0], r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
`endif

  // One-cycle-delayed copies for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  // START/STOP need scl stable high; a coincident scl edge counts as data.
  assign o_sda_lvl = w_sda;
  assign scl_rise  = w_scl & ~r_scl_d;
  assign scl_fall  = ~w_scl & r_scl_d;
  assign start_det = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign stop_det  = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/sccb_slave.sv
// SCCB/I2C register target modelling the OV7670 end of the config bus.
// Optional input glitch filter: define SCCB_GLITCH_FILTER_EN.
module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = OV7670_DEV_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  tri         sda,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       nack_seen
);

  localparam logic [3:0] LAST_BIT  = 4'(SCCB_BITS_PER_BYTE - 1);
  localparam logic [3:0] BYTE_DONE = 4'(SCCB_BITS_PER_BYTE);

  sccb_slave_state_t r_state, w_state_nxt;
  logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_ptr, w_ptr_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_wr_valid, w_wr_valid_nxt;
  logic [7:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0] r_wr_data, w_wr_data_nxt;
  logic       r_nack_seen, w_nack_seen_nxt;

  logic       w_sda_lvl;
  logic       w_rise;
  logic       w_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .i_scl     (scl),
    .i_sda     (sda),
    .o_sda_lvl (w_sda_lvl),
    .scl_rise  (w_rise),
    .scl_fall  (w_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  assign w_byte = {r_shift[6:0], w_sda_lvl};

  // State and datapath registers; sda enable resets so the bus frees at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_nack_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_valid  <= w_wr_valid_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_nack_seen <= w_nack_seen_nxt;
    end
  end

  // Bus protocol sequencing; STOP and START override any state.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_ptr_nxt       = r_ptr;
    w_sda_oe_nxt    = r_sda_oe;
    w_busy_nxt      = r_busy;
    w_wr_valid_nxt  = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_nack_seen_nxt = 1'b0;

    if (w_stop) begin
      w_state_nxt   = IDLE;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_bit_cnt_nxt = '0;
    end else if (w_start) begin
      w_state_nxt   = DEVADDR;
      w_sda_oe_nxt  = 1'b0;
      w_bit_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        DEVADDR: if (w_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = 4'(r_bit_cnt + 4'd1);
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_nxt = '0;
            if (w_byte[7:1] == DEV_ADDR) begin
              w_state_nxt = ACK_DEV;
              w_busy_nxt  = 1'b1;
            end else begin
              w_state_nxt = WAIT_STOP;
            end
          end
        end
        // First fall starts the ACK, second fall ends it; R/W bit is shift[0].
        ACK_DEV: if (w_fall) begin
          if (!r_sda_oe) begin
            w_sda_oe_nxt = 1'b1;
          end else if (r_shift[0]) begin
            w_state_nxt   = RDDATA;
            w_shift_nxt   = rd_data;
            w_sda_oe_nxt  = ~rd_data[7];
            w_bit_cnt_nxt = '0;
          end else begin
            w_state_nxt  = SUBADDR;
            w_sda_oe_nxt = 1'b0;
          end
        end
        SUBADDR: if (w_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = 4'(r_bit_cnt + 4'd1);
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_nxt = '0;
            w_ptr_nxt     = w_byte;
            w_state_nxt   = ACK_SUB;
          end
        end
        ACK_SUB, ACK_WR: if (w_fall) begin
          if (!r_sda_oe) begin
            w_sda_oe_nxt = 1'b1;
          end else begin
            w_sda_oe_nxt = 1'b0;
            w_state_nxt  = WRDATA;
          end
        end
        WRDATA: if (w_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = 4'(r_bit_cnt + 4'd1);
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_nxt  = '0;
            w_wr_valid_nxt = 1'b1;
            w_wr_addr_nxt  = r_ptr;
            w_wr_data_nxt  = w_byte;
            w_ptr_nxt      = 8'(r_ptr + 8'd1);
            w_state_nxt    = ACK_WR;
          end
        end
        // Master samples on rise; next bit is presented on the following fall.
        RDDATA: begin
          if (w_rise) begin
            w_bit_cnt_nxt = 4'(r_bit_cnt + 4'd1);
          end else if (w_fall) begin
            if (r_bit_cnt == BYTE_DONE) begin
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = '0;
              w_state_nxt   = RD_ACK;
            end else begin
              w_shift_nxt  = {r_shift[6:0], r_shift[7]};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end
        end
        RD_ACK: begin
          if (w_rise) begin
            if (w_sda_lvl) begin
              w_nack_seen_nxt = 1'b1;
              w_state_nxt     = WAIT_STOP;
            end else begin
              w_ptr_nxt = 8'(r_ptr + 8'd1);
            end
          end else if (w_fall) begin
            w_state_nxt   = RDDATA;
            w_shift_nxt   = rd_data;
            w_sda_oe_nxt  = ~rd_data[7];
            w_bit_cnt_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda       = r_sda_oe ? 1'b0 : 1'bz;
  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign rd_addr   = r_ptr;
  assign busy      = r_busy;
  assign nack_seen = r_nack_seen;

endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
- SCCB/I2C responder that models the OV7670 camera end of the configuration bus.
- Samples scl/sda in the system clock domain and decodes START, STOP, device address, sub-address and data bytes.
- Emits register-write strobes and serves register reads through a simple register-port interface.
- Used as the bus target for loop-back and bring-up against the on-chip SCCB master; also usable as a generic I2C register target.

Parameters:
- DEV_ADDR, 7'h21, 7-bit device address that is acknowledged (OV7670: write 0x42, read 0x43).
- SYNC_STAGES, 2, flip-flop stages in the scl/sda input synchronizers (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the scl frequency.
- reset  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock, driven by the master.
- sda  inout  tri  bus data, open-drain. This block only ever drives 1'b0 or 'z.
- wr_valid  output  1  one-cycle write strobe.
- wr_addr  output  8  register address for the write strobe.
- wr_data  output  8  register data for the write strobe.
- rd_addr  output  8  current register pointer; the parent returns data combinationally.
- rd_data  input  8  register contents at rd_addr.
- busy  output  1  high from an address-matched START until STOP.
- nack_seen  output  1  one-cycle pulse when the master NACKs a read byte.

Behaviour:
- Reset values:
  - sda released ('z); wr_valid=0, wr_addr=0, wr_data=0, busy=0, nack_seen=0.
  - Register pointer = 0x00; FSM in IDLE.
- Line decode:
  - scl and sda each pass through SYNC_STAGES flip-flops, then a one-cycle-delayed copy for edge detection.
  - START = sda falls while scl is high. STOP = sda rises while scl is high.
  - Data bits are sampled on the synchronized scl rising edge. sda changes only on the synchronized scl falling edge.
- FSM states: IDLE, DEVADDR, ACK_DEV, SUBADDR, ACK_SUB, WRDATA, ACK_WR, RDDATA, RD_ACK, WAIT_STOP.
  - IDLE -(START)-> DEVADDR. Shift in 8 bits MSB first.
  - DEVADDR, address match: go to ACK_DEV. Drive sda low from the falling edge after bit 8 until the next falling edge.
  - DEVADDR, mismatch: go to WAIT_STOP. sda is never driven.
  - ACK_DEV with R/W=0 -> SUBADDR. ACK_DEV with R/W=1 -> RDDATA.
  - SUBADDR: 8 bits -> ACK_SUB. Pointer is loaded at the end of bit 8; the byte is ACKed.
  - ACK_SUB -> WRDATA.
  - WRDATA: 8 bits -> ACK_WR, with the byte ACKed.
    - wr_valid pulses exactly one clk cycle, the cycle after the 8th bit is sampled.
    - wr_addr = pointer, wr_data = received byte.
    - Pointer then increments, wrapping 0xFF->0x00. ACK_WR -> WRDATA.
  - RDDATA:
    - rd_data is latched into the shift register on the scl falling edge that ends ACK_DEV or RD_ACK.
    - MSB is driven immediately. A bit value of 1 releases sda; 0 drives it low.
    - After 8 bits, sda is released -> RD_ACK.
  - RD_ACK:
    - Master ACK (sda=0) at the 9th rising edge: pointer++ (wraps) -> RDDATA.
    - Master NACK: nack_seen pulse -> WAIT_STOP.
  - Matched read with no preceding sub-address phase (SCCB two-phase read) uses the retained pointer.
- START (including repeated START) in any state: sda released, go to DEVADDR, bit counter cleared, pointer retained.
- STOP in any state: sda released, go to IDLE, busy=0.
- A partial byte at START or STOP is discarded; no wr_valid is issued.
- Asynchronous reset mid-transaction: immediate return to the reset values. The bus is released within 0 clk cycles, because the sda enable is a register with asynchronous reset.
- Simultaneous scl and sda edges in the same synchronized cycle: treated as a data bit, not START/STOP. The master must honour the setup time.

Optional Feature:
- Macro: SCCB_GLITCH_FILTER_EN.
- Defined: each synchronized line passes through a 3-sample majority filter before edge detection. This adds 2 clk cycles of latency to every decoded event and rejects pulses of 1 clk cycle or less.
- Undefined: there is no filter, and edges are taken directly from the synchronizer output.

Decomposition:
- Package sccb_pkg holds:
  - the FSM state enum (sccb_slave_state_t);
  - the constant OV7670_DEV_ADDR = 7'h21;
  - the constant SCCB_BITS_PER_BYTE = 8.
- One sub-module, sccb_line_sync, contains the synchronizers, the optional filter, the edge registers and the scl_rise, scl_fall, start_det and stop_det outputs.

Test Plan:
- Write 0x42, 0x12, 0x80, STOP -> three ACKs; one wr_valid with wr_addr=0x12, wr_data=0x80; busy returns to 0 after STOP.
- Address 0x60 (mismatch) then 0x12 -> sda never driven low; wr_valid stays 0; busy stays 0.
- Burst write 0x42, 0xFE, 0xA1, 0xB2, 0xC3 -> writes to 0xFE, 0xFF and 0x00 (pointer wrap), with data A1, B2, C3.
- Write 0x42, 0x0A, STOP; then 0x43 with rd_data=0x5C, master ACK, rd_data=0x7E, master NACK -> bus carries 0x5C then 0x7E; rd_addr shows 0x0A then 0x0B; one nack_seen pulse.
- Repeated START after 4 data bits of WRDATA, then 0x42, 0x20, 0x11 -> no write for the partial byte; one write 0x20<-0x11.
- Assert reset while the slave drives an ACK low -> sda released in the same cycle; FSM in IDLE; pointer 0x00.
